// File: rtl/sram_arbiter_2p.sv
// sram_arbiter_2p
//   Two-client round-robin arbiter and sequencer for the SRAM controller's
//   user port. Each client holds req (with rw/addr/wdata stable) until it sees
//   a one-cycle done pulse; err pulses with done when the controller failed to
//   respond within TIMEOUT cycles. rdata* holds the last read result per client.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req*/rw*/addr*/wdata*  client requests (rw: 1=read, 0=write)
//   done*/err*/rdata*   client completion pulse, timeout flag, read data
//   mem/rw/addr/data_f2s  controller command (mem is a one-cycle strobe)
//   ready/data_s2f      controller idle/complete indicator and read data
//   busy                high whenever a transaction is in flight
//   last_grant          index of the most recently granted client
module sram_arbiter_2p #(
  parameter int AW      = 18,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          rw0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          done0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          done1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic          mem,
  output logic          rw,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_f2s,
  input  logic          ready,
  input  logic [DW-1:0] data_s2f,
  output logic          busy,
  output logic          last_grant
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE} state_t;

  // Counter can step one past TIMEOUT-1 on the WAIT_LO->WAIT_HI transition,
  // so it is sized to hold TIMEOUT itself; the limit test uses >=.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_q, mem_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_f2s_q, data_f2s_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          busy_q, busy_d;
  logic          last_grant_q, last_grant_d;
  logic          gnt;
  logic          finish_ok, finish_err;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_d        = 1'b0;
    rw_d         = rw_q;
    addr_d       = addr_q;
    data_f2s_d   = data_f2s_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    busy_d       = busy_q;
    last_grant_d = last_grant_q;
    gnt          = last_grant_q;
    finish_ok    = 1'b0;
    finish_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ready && (req0 || req1)) begin
          // Contested: the client that did not win last time goes first.
          gnt          = (req0 && req1) ? ~last_grant_q : req1;
          last_grant_d = gnt;
          rw_d         = gnt ? rw1 : rw0;
          addr_d       = gnt ? addr1 : addr0;
          data_f2s_d   = gnt ? wdata1 : wdata0;
          mem_d        = 1'b1;
          busy_d       = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!ready) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = WAIT_HI;
        end else if (cnt_q >= CNT_LAST) begin
          finish_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HI: begin
        if (ready) begin
          finish_ok = 1'b1;
        end else if (cnt_q >= CNT_LAST) begin
          finish_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (finish_ok || finish_err) begin
      state_d = DONE;
      if (last_grant_q) begin
        done1_d = 1'b1;
        err1_d  = finish_err;
      end else begin
        done0_d = 1'b1;
        err0_d  = finish_err;
      end
      if (finish_ok && rw_q) begin
        if (last_grant_q) rdata1_d = data_s2f;
        else              rdata0_d = data_s2f;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_q        <= 1'b0;
      rw_q         <= 1'b1;
      addr_q       <= '0;
      data_f2s_q   <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      data_f2s_q   <= data_f2s_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign mem        = mem_q;
  assign rw         = rw_q;
  assign addr       = addr_q;
  assign data_f2s   = data_f2s_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign err0       = err0_q;
  assign err1       = err1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign busy       = busy_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
module tb_sram_arbiter_2p;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, rw0, req1, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, err0, done1, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem, rw, ready, busy, last_grant;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_f2s, data_s2f;

  always #5 clk = ~clk;

  sram_arbiter_2p #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .err1(err1), .rdata1(rdata1),
    .mem(mem), .rw(rw), .addr(addr), .data_f2s(data_f2s),
    .ready(ready), .data_s2f(data_s2f),
    .busy(busy), .last_grant(last_grant)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- controller model ----------------
  // Acknowledges a mem strobe by dropping ready lo negedges later, keeps it
  // low for hi negedges, then returns read data / commits write data.
  logic [DW-1:0] ctl_mem [256];
  bit            ctl_stuck = 1'b0;
  bit            ctl_rand  = 1'b0;
  int            ctl_lo = 1, ctl_hi = 1;
  int            c_lo, c_hi;
  logic          c_rw;
  logic [7:0]    c_a;
  logic [DW-1:0] c_d;

  initial begin
    for (int i = 0; i < 256; i++) ctl_mem[i] = '0;
    ready    = 1'b1;
    data_s2f = '0;
    forever begin
      @(negedge clk);
      if (mem === 1'b1 && !ctl_stuck) begin
        c_lo = ctl_rand ? int'($urandom_range(2, 1)) : ctl_lo;
        c_hi = ctl_rand ? int'($urandom_range(3, 1)) : ctl_hi;
        c_rw = rw;
        c_a  = addr[7:0];
        c_d  = data_f2s;
        repeat (c_lo) @(negedge clk);
        ready = 1'b0;
        repeat (c_hi) @(negedge clk);
        if (c_rw) data_s2f = ctl_mem[c_a];
        else      ctl_mem[c_a] = c_d;
        ready = 1'b1;
      end
    end
  end

  // ---------------- transaction-level reference scoreboard ----------------
  logic [DW-1:0] ref_mem [256];
  bit            sb_on = 1'b0;
  logic [1:0]    req_hist = 2'b00;
  bit            last_m;
  bit            pend, pend_g, pend_rd, g;
  logic [DW-1:0] exp_rd;
  int            grants = 0, dones = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (sb_on) begin
        if (mem) begin
          if (req_hist == 2'b00) begin
            chk("sb_grant_without_req", 32'(req_hist), 32'd1);
            g = last_m;
          end else if (req_hist == 2'b11) begin
            g = ~last_m;
          end else begin
            g = req_hist[1];
          end
          chk("sb_overlap", 32'(pend), 32'd0);
          chk("sb_rw", 32'(rw), 32'(g ? rw1 : rw0));
          chk("sb_addr", 32'(addr), 32'(g ? addr1 : addr0));
          chk("sb_wdata", 32'(data_f2s), 32'(g ? wdata1 : wdata0));
          chk("sb_last_grant", 32'(last_grant), 32'(g));
          pend    = 1'b1;
          pend_g  = g;
          pend_rd = g ? rw1 : rw0;
          if (pend_rd) exp_rd = ref_mem[g ? addr1[7:0] : addr0[7:0]];
          else ref_mem[g ? addr1[7:0] : addr0[7:0]] = g ? wdata1 : wdata0;
          last_m = g;
          grants++;
        end
        if (done0 || done1) begin
          chk("sb_done_expected", 32'(pend), 32'd1);
          chk("sb_done_who", 32'({done1, done0}), pend_g ? 32'd2 : 32'd1);
          chk("sb_err", 32'({err1, err0}), 32'd0);
          if (pend_rd) chk("sb_rdata", 32'(pend_g ? rdata1 : rdata0), 32'(exp_rd));
          pend = 1'b0;
          dones++;
        end
      end
      req_hist = {req1, req0};
    end
  end

  // ---------------- table-driven single transactions ----------------
  typedef struct {
    bit            cl;
    bit            rd;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            lo;
    int            hi;
    bit            stuck;
    int            lat;
    bit            err;
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
  } vec_t;

  vec_t vt [8];

  task automatic run_vec(input vec_t v, input int idx);
    int   mem_cnt, mem_c, done_c, own_done, other_ev;
    logic dn_own, er_own, dn_oth, er_oth;
    mem_cnt = 0; mem_c = -1; done_c = -1; own_done = 0; other_ev = 0;
    @(negedge clk);
    ctl_stuck = v.stuck; ctl_lo = v.lo; ctl_hi = v.hi;
    if (v.cl) begin rw1 = v.rd; addr1 = v.a; wdata1 = v.wd; req1 = 1'b1; end
    else      begin rw0 = v.rd; addr0 = v.a; wdata0 = v.wd; req0 = 1'b1; end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      dn_own = v.cl ? done1 : done0;
      er_own = v.cl ? err1  : err0;
      dn_oth = v.cl ? done0 : done1;
      er_oth = v.cl ? err0  : err1;
      if (mem) begin
        mem_cnt++;
        if (mem_c < 0) begin
          mem_c = c;
          chk($sformatf("v%0d_rw", idx), 32'(rw), 32'(v.rd));
          chk($sformatf("v%0d_addr", idx), 32'(addr), 32'(v.a));
          chk($sformatf("v%0d_data_f2s", idx), 32'(data_f2s), 32'(v.wd));
          chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
          chk($sformatf("v%0d_last_grant", idx), 32'(last_grant), 32'(v.cl));
        end
      end
      if (dn_own) begin
        own_done++;
        if (done_c < 0) begin
          done_c = c;
          chk($sformatf("v%0d_err", idx), 32'(er_own), 32'(v.err));
          chk($sformatf("v%0d_rdata0", idx), 32'(rdata0), 32'(v.r0));
          chk($sformatf("v%0d_rdata1", idx), 32'(rdata1), 32'(v.r1));
        end
        req0 = 1'b0; req1 = 1'b0;
      end else if (er_own) begin
        other_ev++;
      end
      if (dn_oth || er_oth) other_ev++;
    end
    req0 = 1'b0; req1 = 1'b0; ctl_stuck = 1'b0;
    chk($sformatf("v%0d_mem_count", idx), 32'(mem_cnt), 32'd1);
    chk($sformatf("v%0d_done_count", idx), 32'(own_done), 32'd1);
    chk($sformatf("v%0d_other_client", idx), 32'(other_ev), 32'd0);
    chk($sformatf("v%0d_latency", idx), 32'(done_c - mem_c), 32'(v.lat));
    chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- random clients ----------------
  task automatic client(input int id, input int n, output int served);
    bit got;
    served = 0;
    for (int t = 0; t < n; t++) begin
      if (id == 1) begin
        rw1 = 1'($urandom_range(1, 0)); addr1 = AW'($urandom_range(15, 0));
        wdata1 = DW'($urandom); req1 = 1'b1;
      end else begin
        rw0 = 1'($urandom_range(1, 0)); addr0 = AW'($urandom_range(15, 0));
        wdata0 = DW'($urandom); req0 = 1'b1;
      end
      got = 1'b0;
      for (int c = 0; c < 60; c++) begin
        @(posedge clk); #2;
        if ((id == 1) ? done1 : done0) begin got = 1'b1; break; end
      end
      chk($sformatf("client%0d_done_wait", id), 32'(got), 32'd1);
      if (!got) break;
      served++;
      if ($urandom_range(1, 0) == 0) begin
        if (id == 1) req1 = 1'b0; else req0 = 1'b0;
        repeat ($urandom_range(2, 0)) begin @(posedge clk); #2; end
      end
    end
    if (id == 1) req1 = 1'b0; else req0 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int k, last_done, mem_total, mem_c, rise_c, s0, s1;
  bit found, gexp;

  initial begin
    vt[0] = '{cl:0, rd:0, a:18'h000F0, wd:16'h00F0, lo:1, hi:3, stuck:0, lat:5, err:0, r0:16'h0000, r1:16'h0000};
    vt[1] = '{cl:1, rd:1, a:18'h000F0, wd:16'h0000, lo:1, hi:3, stuck:0, lat:5, err:0, r0:16'h0000, r1:16'h00F0};
    vt[2] = '{cl:0, rd:0, a:18'h00012, wd:16'hBEEF, lo:2, hi:1, stuck:0, lat:4, err:0, r0:16'h0000, r1:16'h00F0};
    vt[3] = '{cl:0, rd:1, a:18'h00012, wd:16'h0000, lo:1, hi:1, stuck:0, lat:3, err:0, r0:16'hBEEF, r1:16'h00F0};
    vt[4] = '{cl:1, rd:0, a:18'h00012, wd:16'h1234, lo:1, hi:1, stuck:1, lat:9, err:1, r0:16'hBEEF, r1:16'h00F0};
    vt[5] = '{cl:1, rd:1, a:18'h00012, wd:16'h0000, lo:1, hi:1, stuck:1, lat:9, err:1, r0:16'hBEEF, r1:16'h00F0};
    vt[6] = '{cl:1, rd:1, a:18'h00012, wd:16'h0000, lo:1, hi:2, stuck:0, lat:4, err:0, r0:16'hBEEF, r1:16'hBEEF};
    vt[7] = '{cl:0, rd:1, a:18'h000F0, wd:16'h0000, lo:2, hi:3, stuck:0, lat:6, err:0, r0:16'h00F0, r1:16'hBEEF};

    reset = 1'b1;
    req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; rw1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem", 32'(mem), 32'd0);
    chk("rst_rw", 32'(rw), 32'd1);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data_f2s", 32'(data_f2s), 32'd0);
    chk("rst_done_err", 32'({done1, err1, done0, err0}), 32'd0);
    chk("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last_grant", 32'(last_grant), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // Both clients held for four writes: strict 0,1,0,1 alternation.
    do_reset();
    ctl_lo = 1; ctl_hi = 1;
    @(negedge clk);
    rw0 = 1'b0; addr0 = 18'h00020; wdata0 = 16'hAAAA; req0 = 1'b1;
    rw1 = 1'b0; addr1 = 18'h00021; wdata1 = 16'h5555; req1 = 1'b1;
    k = 0; last_done = -10; mem_total = 0;
    for (int c = 0; c < 80 && k < 4; c++) begin
      @(negedge clk);
      gexp = 1'(k % 2);
      if (mem) begin
        mem_total++;
        chk("rr_addr", 32'(addr), gexp ? 32'h21 : 32'h20);
        chk("rr_data_f2s", 32'(data_f2s), gexp ? 32'h5555 : 32'hAAAA);
        chk("rr_last_grant", 32'(last_grant), 32'(gexp));
        if (k > 0) chk("rr_regrant_gap", 32'(c - last_done), 32'd2);
      end
      if (done0 || done1) begin
        chk("rr_done_who", 32'({done1, done0}), gexp ? 32'd2 : 32'd1);
        last_done = c;
        k++;
        if (k == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (6) begin @(negedge clk); if (mem) mem_total++; end
    chk("rr_done_count", 32'(k), 32'd4);
    chk("rr_mem_count", 32'(mem_total), 32'd4);

    // Reset during WAIT_HI, then grant held off until ready returns.
    ctl_lo = 1; ctl_hi = 5;
    @(negedge clk);
    rw0 = 1'b1; addr0 = 18'h00012; wdata0 = '0; req0 = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem) begin found = 1'b1; break; end
    end
    chk("rst_mid_mem_seen", 32'(found), 32'd1);
    @(negedge clk); @(negedge clk);
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_mem", 32'(mem), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'({done1, done0}), 32'd0);
    chk("rst_mid_last_grant", 32'(last_grant), 32'd1);
    chk("rst_mid_rw", 32'(rw), 32'd1);
    chk("rst_mid_addr", 32'(addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ctl_hi = 2;
    rise_c = -1; mem_c = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (ready && rise_c < 0) rise_c = c;
      if (mem) begin mem_c = c; break; end
    end
    chk("rst_mid_ready_rose", 32'(rise_c >= 1), 32'd1);
    chk("rst_mid_grant_after_ready", 32'(mem_c - rise_c), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done0) begin found = 1'b1; break; end
    end
    req0 = 1'b0;
    chk("rst_mid_done0", 32'(found), 32'd1);
    chk("rst_mid_rdata0", 32'(rdata0), 32'hBEEF);

    // Randomized two-client traffic against the reference scoreboard.
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = ctl_mem[i];
    last_m = 1'b1; pend = 1'b0;
    ctl_rand = 1'b1;
    @(posedge clk); #2;
    sb_on = 1'b1;
    fork
      client(0, 30, s0);
      client(1, 30, s1);
    join
    repeat (20) @(negedge clk);
    sb_on = 1'b0;
    chk("rand_grants_vs_dones", 32'(grants), 32'(dones));
    chk("rand_grants_vs_served", 32'(grants), 32'(s0 + s1));
    chk("rand_pending", 32'(pend), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter_2p.md
Name: sram_arbiter_2p

Overview:
- Two-requester round-robin arbiter and sequencer in front of the SRAM controller's user port (mem/rw/addr/data_f2s/ready/data_s2f_r).
- Lets two independent clients, e.g. a switch/button front end and a pattern generator, share one SRAM.
- Each client gets a simple req/done handshake and per-client read data; the block issues one-cycle mem strobes and tracks controller completion through ready.
- A timeout watchdog keeps a client from hanging when the controller fails to respond.

Parameters:
- AW, 18, SRAM word address width
- DW, 16, SRAM data width
- TIMEOUT, 255, maximum cycles spent waiting on the controller before aborting (must be >= 2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0  in  1  client 0 request; held high with rw0/addr0/wdata0 stable until done0
- rw0  in  1  client 0 direction: 1=read, 0=write
- addr0  in  AW  client 0 address
- wdata0  in  DW  client 0 write data
- done0  out  1  one-cycle completion pulse to client 0
- err0  out  1  one-cycle timeout pulse to client 0, coincident with done0
- rdata0  out  DW  client 0 read data, valid from done0 until the next client 0 read completes
- req1, rw1, addr1, wdata1, done1, err1, rdata1  same as client 0, for client 1
- mem  out  1  controller start strobe
- rw  out  1  controller direction
- addr  out  AW  controller address
- data_f2s  out  DW  controller write data
- ready  in  1  controller idle/complete indicator
- data_s2f  in  DW  controller registered read data
- busy  out  1  high in every state except IDLE
- last_grant  out  1  index of the most recently granted client

Behaviour:
- All outputs registered. Reset values: mem=0, rw=1, addr=0, data_f2s=0, done*/err*=0, rdata*=0, busy=0, last_grant=1 (so client 0 wins the first tie), state=IDLE, timeout counter=0.
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE.
- IDLE: when ready=1 and at least one req is high, grant at the clock edge:
  - single requester: that client is granted;
  - both requesting: the client != last_grant is granted.
  - On grant: latch rw/addr/wdata of the granted client into rw/addr/data_f2s, update last_grant, go to ISSUE.
  - If ready=0, no grant; stay in IDLE.
- ISSUE: mem=1 for exactly this one cycle; go to WAIT_LO and clear the counter. mem rises one cycle after the edge that sampled req.
- WAIT_LO: wait for ready=0 (controller accepted). Then go to WAIT_HI; the counter keeps running.
- WAIT_HI: wait for ready=1. At that edge:
  - if the latched rw=1, capture data_s2f into rdata of the granted client;
  - go to DONE.
- Timeout: the counter increments every cycle in WAIT_LO/WAIT_HI. If it reaches TIMEOUT-1 without the exit condition, go to DONE with the error flag set; rdata is unchanged.
- DONE: done of the granted client is high for this one cycle, plus err if the error flag is set; next state IDLE. Requests are not sampled in DONE, so a client dropping req on done is never re-granted.
- Holding req through done starts a new transaction: re-granted in the following IDLE cycle if uncontested; if contested, the other client wins.
- addr/rw/data_f2s hold their latched values from ISSUE until the next grant. Write data is never altered mid-operation.
- Client req deassertion after grant does not abort; done still pulses.
- Client input changes after grant are ignored; latched values are used.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values, mem=0 asynchronously. The controller may still complete the operation; the arbiter waits for ready=1 in IDLE before the next grant.
- busy=1 in ISSUE/WAIT_LO/WAIT_HI/DONE.

Test Plan:
- Client 0 write, addr=0x000F0, wdata=0x00F0, ready drops 1 cycle after mem and returns 3 cycles later -> one mem pulse; rw=0; addr=0x000F0; data_f2s=0x00F0; done0 pulses once; err0=0; done1 never pulses.
- Client 1 read of 0x000F0 after the write, model returns data_s2f=0x00F0 when ready rises -> rdata1=0x00F0 at done1; rdata0 unchanged at 0.
- req0 and req1 asserted together and held for 4 transactions -> grant order 0,1,0,1; last_grant toggles; exactly one mem per transaction.
- TIMEOUT=8 with ready stuck at 1 after mem -> done0 and err0 pulse together 9 cycles after mem; rdata0 unchanged; the next request is served normally.
- ready=0 when req0 rises -> no mem until ready=1; mem then follows 1 cycle later.
- reset asserted during WAIT_HI -> mem/busy/done*=0 immediately; after release, last_grant=1 and the state is IDLE.
